// File: rtl/syn_pkg.sv
// Protocol constants shared by the sync-line master generators and the slave receiver.
package syn_pkg;

  localparam int SYNC_US_DEF = 8;    // sync-marker low width, microseconds
  localparam int BIT_CYC_DEF = 100;  // info bit period, clk_sys cycles
  localparam int INFO_W_DEF  = 32;   // info word width
  localparam int LOCK_W      = 21;   // width of the link-lock microsecond counter

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC_LOW,
    ST_ABORT,
    ST_WAIT_START,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/syn_s_rx_sync.sv
// Brings the asynchronous sync line into clk_sys and decodes its edges.
module syn_s_rx_sync (
  input  logic clk_sys,
  input  logic rst,
  input  logic rx_syn,
  output logic line,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s2_d;

  // Two-flop synchroniser plus one edge register; all idle high so reset never looks like an edge.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s2_d <= 1'b1;
    end else begin
      s1   <= rx_syn;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign line = s2;
  assign rise = s2 & ~s2_d;
  assign fall = ~s2 & s2_d;

endmodule

// File: rtl/syn_s_rx.sv
// Slave sync-line receiver: regenerates fire_sync at the end of the master's marker,
// deserialises the trailing info word and tracks link lock.
module syn_s_rx
  import syn_pkg::*;
#(
  parameter int SYNC_US    = SYNC_US_DEF,
  parameter int BIT_CYC    = BIT_CYC_DEF,
  parameter int INFO_W     = INFO_W_DEF,
  parameter int INFO_TO_US = 50,
  parameter int LOCK_TO_US = 1100000
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              pluse_us,
  input  logic              rx_syn,
  output logic              fire_sync,
  output logic [INFO_W-1:0] info_data,
  output logic              info_vld,
  output logic              err_sync,
  output logic              err_info,
  output logic              sync_lock
);

  localparam int US_MAX = (INFO_TO_US > SYNC_US + 2) ? INFO_TO_US : SYNC_US + 2;
  localparam int US_W   = $clog2(US_MAX + 1);
  localparam int TM_W   = $clog2(BIT_CYC);
  localparam int BC_W   = $clog2(INFO_W);

  localparam logic [US_W-1:0]   SYNC_LO  = US_W'(SYNC_US - 1);
  localparam logic [US_W-1:0]   SYNC_HI  = US_W'(SYNC_US + 1);
  localparam logic [US_W-1:0]   INFO_TO  = US_W'(INFO_TO_US);
  localparam logic [TM_W-1:0]   T_HALF   = TM_W'(BIT_CYC / 2 - 1);
  localparam logic [TM_W-1:0]   T_FULL   = TM_W'(BIT_CYC - 1);
  localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(INFO_W - 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_TO_US);

  logic line;
  logic rise;
  logic fall;

  rx_state_t         state,     state_nxt;
  logic [US_W-1:0]   us_cnt,    us_nxt;
  logic [TM_W-1:0]   tmr,       tmr_nxt;
  logic [BC_W-1:0]   bcnt,      bcnt_nxt;
  logic [INFO_W-1:0] shreg,     shreg_nxt;
  logic [INFO_W-1:0] data_nxt;
  logic              fire_nxt;
  logic              vld_nxt;
  logic              esync_nxt;
  logic              einfo_nxt;
  logic [US_W-1:0]   us_inc;
  logic              tmr_exp;
  logic [LOCK_W-1:0] lock_cnt;

  syn_s_rx_sync u_sync (
    .clk_sys (clk_sys),
    .rst     (rst),
    .rx_syn  (rx_syn),
    .line    (line),
    .rise    (rise),
    .fall    (fall)
  );

  // The tick is added before any window compare so a coincident tick and edge see the new count.
  assign us_inc  = us_cnt + {{(US_W-1){1'b0}}, pluse_us};
  assign tmr_exp = (tmr == '0);

  // Receiver state register plus all registered outputs, so fire_sync has a fixed edge-to-pulse delay.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      us_cnt    <= '0;
      tmr       <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      info_data <= '0;
      fire_sync <= 1'b0;
      info_vld  <= 1'b0;
      err_sync  <= 1'b0;
      err_info  <= 1'b0;
    end else begin
      state     <= state_nxt;
      us_cnt    <= us_nxt;
      tmr       <= tmr_nxt;
      bcnt      <= bcnt_nxt;
      shreg     <= shreg_nxt;
      info_data <= data_nxt;
      fire_sync <= fire_nxt;
      info_vld  <= vld_nxt;
      err_sync  <= esync_nxt;
      err_info  <= einfo_nxt;
    end
  end

  // Next-state, counters and pulse outputs of the marker/frame decoder.
  always_comb begin
    state_nxt = state;
    us_nxt    = us_cnt;
    tmr_nxt   = tmr;
    bcnt_nxt  = bcnt;
    shreg_nxt = shreg;
    data_nxt  = info_data;
    fire_nxt  = 1'b0;
    vld_nxt   = 1'b0;
    esync_nxt = 1'b0;
    einfo_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          us_nxt    = '0;
          state_nxt = ST_SYNC_LOW;
        end
      end
      ST_SYNC_LOW: begin
        us_nxt = us_inc;
        if (rise) begin
          if (us_inc >= SYNC_LO && us_inc <= SYNC_HI) begin
            fire_nxt  = 1'b1;
            us_nxt    = '0;
            state_nxt = ST_WAIT_START;
          end else begin
            esync_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (us_inc > SYNC_HI) begin
          esync_nxt = 1'b1;
          state_nxt = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (line) state_nxt = ST_IDLE;
      end
      ST_WAIT_START: begin
        us_nxt = us_inc;
        if (fall) begin
          tmr_nxt   = T_HALF;
          state_nxt = ST_START;
        end else if (us_inc == INFO_TO) begin
          einfo_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (!tmr_exp) begin
          tmr_nxt = tmr - TM_W'(1);
        end else if (line) begin
          einfo_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          tmr_nxt   = T_FULL;
          bcnt_nxt  = '0;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!tmr_exp) begin
          tmr_nxt = tmr - TM_W'(1);
        end else begin
          shreg_nxt = {line, shreg[INFO_W-1:1]};
          tmr_nxt   = T_FULL;
          bcnt_nxt  = bcnt + BC_W'(1);
          if (bcnt == BC_LAST) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!tmr_exp) begin
          tmr_nxt = tmr - TM_W'(1);
        end else if (line) begin
          data_nxt  = shreg;
          vld_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          einfo_nxt = 1'b1;
          state_nxt = ST_ABORT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Link lock: saturating us counter restarted by each good word; any error drops lock at once.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      lock_cnt  <= '0;
      sync_lock <= 1'b0;
    end else begin
      if (info_vld)
        lock_cnt <= '0;
      else if (pluse_us && lock_cnt != LOCK_MAX)
        lock_cnt <= lock_cnt + LOCK_W'(1);

      if (err_sync || err_info)
        sync_lock <= 1'b0;
      else if (info_vld)
        sync_lock <= 1'b1;
      else if (lock_cnt == LOCK_MAX)
        sync_lock <= 1'b0;
    end
  end

endmodule

// File: tb/tb_syn_s_rx.sv
// Bench for syn_s_rx: directed line waveforms, expected pulses queued by the stimulus
// and consumed by an independent monitor. One microsecond is 10 clk_sys cycles here.
module tb_syn_s_rx;

  localparam int US_CLK  = 10;
  localparam int BIT_CYC = 100;
  localparam int LOCK_US = 1000;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        pluse_us;
  logic        rx_syn;
  logic        fire_sync;
  logic [31:0] info_data;
  logic        info_vld;
  logic        err_sync;
  logic        err_info;
  logic        sync_lock;

  typedef struct {
    logic [3:0]  ev;    // {fire_sync, info_vld, err_sync, err_info}
    logic [31:0] data;
    int          cyc;   // required cycle, -1 = not timed
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  int   us_since = 0;
  int   hit_cyc  = -1;
  int   drop_cyc = -1;
  logic prev_lock = 1'b0;

  syn_s_rx #(
    .SYNC_US    (8),
    .BIT_CYC    (BIT_CYC),
    .INFO_W     (32),
    .INFO_TO_US (50),
    .LOCK_TO_US (LOCK_US)
  ) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .pluse_us  (pluse_us),
    .rx_syn    (rx_syn),
    .fire_sync (fire_sync),
    .info_data (info_data),
    .info_vld  (info_vld),
    .err_sync  (err_sync),
    .err_info  (err_info),
    .sync_lock (sync_lock)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Microsecond tick: one cycle high every US_CLK cycles.
  initial begin
    int pc = 0;
    pluse_us = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      pc++;
      pluse_us = (pc % US_CLK == 0);
    end
  end

  // Monitor: pops one expectation per output pulse; also timestamps lock timing.
  always @(negedge clk_sys) begin
    logic [3:0] ev;
    exp_t e;
    if (rst) begin
      prev_lock = 1'b0;
    end else begin
      ev = {fire_sync, info_vld, err_sync, err_info};
      if (ev != 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", ev, 0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", ev, e.ev);
          if (e.cyc >= 0) chk("event_latency", cyc, e.cyc);
          if (e.ev[2]) chk("vld_info_data", info_data, e.data);
        end
      end
      if (info_vld) us_since = 0;
      else if (pluse_us && us_since < LOCK_US) begin
        us_since++;
        if (us_since == LOCK_US) hit_cyc = cyc;
      end
      if (prev_lock && !sync_lock) drop_cyc = cyc;
      prev_lock = sync_lock;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input logic [3:0] ev, input logic [31:0] d, input int c);
    exp_t e;
    e.ev = ev; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Low for us microseconds; ok markers expect fire_sync exactly 3 cycles after the rising edge.
  task automatic marker(input int us, input bit ok);
    if (!ok) push(4'b0010, '0, -1);
    rx_syn = 1'b0;
    clks(us * US_CLK);
    rx_syn = 1'b1;
    if (ok) push(4'b1000, '0, cyc + 3);
  endtask

  task automatic frame(input logic [31:0] d, input logic stop_bit);
    marker(8, 1'b1);
    clks(3 * US_CLK);
    rx_syn = 1'b0;
    clks(BIT_CYC);
    for (int i = 0; i < 32; i++) begin
      rx_syn = d[i];
      clks(BIT_CYC);
    end
    if (stop_bit) push(4'b0100, d, -1);
    else          push(4'b0001, '0, -1);
    rx_syn = stop_bit;
    clks(BIT_CYC);
    rx_syn = 1'b1;
    clks(20 * US_CLK);
  endtask

  initial begin
    logic [31:0] d;
    int d0;
    rst    = 1'b1;
    rx_syn = 1'b1;
    clks(3);
    chk("rst_fire_sync", fire_sync, 0);
    chk("rst_info_vld",  info_vld,  0);
    chk("rst_err_sync",  err_sync,  0);
    chk("rst_err_info",  err_info,  0);
    chk("rst_sync_lock", sync_lock, 0);
    chk("rst_info_data", info_data, 0);
    rst = 1'b0;
    clks(20);

    frame(32'hA5C3_0F81, 1'b1);
    chk("f1_data", info_data, 32'hA5C3_0F81);
    chk("f1_lock", sync_lock, 1);

    marker(6, 1'b0);
    clks(10 * US_CLK);
    chk("short_marker_lock", sync_lock, 0);
    marker(10, 1'b0);
    clks(10 * US_CLK);
    marker(20, 1'b0);
    clks(10 * US_CLK);

    frame(32'h8000_0001, 1'b1);
    chk("after_abort_data", info_data, 32'h8000_0001);
    chk("after_abort_lock", sync_lock, 1);

    // No start bit: err_info at 50 us, lock lost, data kept.
    marker(8, 1'b1);
    push(4'b0001, '0, -1);
    clks(60 * US_CLK);
    chk("timeout_lock", sync_lock, 0);
    chk("timeout_data", info_data, 32'h8000_0001);

    // 20-cycle glitch after the marker is a false start.
    marker(8, 1'b1);
    push(4'b0001, '0, -1);
    clks(3 * US_CLK);
    rx_syn = 1'b0;
    clks(20);
    rx_syn = 1'b1;
    clks(15 * US_CLK);

    frame(32'h1234_5678, 1'b0);
    chk("badstop_data", info_data, 32'h8000_0001);

    // Two frames inside the lock window keep lock without a drop.
    frame(32'hFFFF_FFFE, 1'b1);
    chk("lockA_lock", sync_lock, 1);
    d0 = drop_cyc;
    clks(500 * US_CLK);
    frame(32'h0000_0001, 1'b1);
    chk("lockB_lock", sync_lock, 1);
    chk("lock_held_no_drop", drop_cyc, d0);
    chk("lockB_data", info_data, 32'h0000_0001);

    // Silence: lock drops two cycles after the LOCK_US-th tick following the last info_vld.
    clks((LOCK_US + 50) * US_CLK);
    chk("lock_timeout_lock", sync_lock, 0);
    chk("lock_timeout_cycle", drop_cyc, hit_cyc + 2);

    frame(32'h5A5A_C3C3, 1'b1);
    chk("pre_rst_data", info_data, 32'h5A5A_C3C3);

    // Reset in the middle of DATA.
    marker(8, 1'b1);
    clks(3 * US_CLK);
    rx_syn = 1'b0;
    clks(BIT_CYC);
    d = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      rx_syn = d[i];
      clks(BIT_CYC);
    end
    rst = 1'b1;
    #1;
    chk("midrst_info_data", info_data, 0);
    chk("midrst_sync_lock", sync_lock, 0);
    chk("midrst_pulses", {fire_sync, info_vld, err_sync, err_info}, 0);
    rx_syn = 1'b1;
    clks(5);
    rst = 1'b0;
    clks(20);

    frame(32'h0F0F_1E2D, 1'b1);
    chk("post_rst_data", info_data, 32'h0F0F_1E2D);
    chk("post_rst_lock", sync_lock, 1);

    clks(50);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
